// File: rtl/replicated_serializer_pkg.sv
// Shared types and helpers for the replicated result serializer.
// State encoding, result-width multiplier and the width helper used by the top.
package replicated_serializer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int RESULT_WIDTH_MULT = 4;

  function automatic int result_width(input int w);
    return RESULT_WIDTH_MULT * w;
  endfunction

endpackage

// File: rtl/replicated_result_serializer_vector_fifo.sv
// Synchronous FIFO of whole packed result vectors (module vector_fifo).
// Head word is read combinationally so the serializer can index lanes without a bubble.
module vector_fifo #(
  parameter int WORD_W = 256,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wr_data,
  output logic [WORD_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;

  // Storage carries no reset: stale words are never visible because out_data is gated by state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[head_reg];
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/replicated_result_serializer.sv
// Captures N-lane result vectors into a vector FIFO and streams them one lane per beat.
// Optional out_lane port is enabled by defining SERIALIZER_LANE_ID_EN.
module replicated_result_serializer
  import replicated_serializer_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int NUM_REPLICATIONS = 8,
  parameter int DEPTH            = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [result_width(WIDTH)-1:0]      in [NUM_REPLICATIONS],
  input  logic                                valid_in,
  output logic                                in_ready,
  output logic [result_width(WIDTH)-1:0]      out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
`ifdef SERIALIZER_LANE_ID_EN
  output logic [$clog2(NUM_REPLICATIONS)-1:0] out_lane,
`endif
  output logic                                overflow
);

  localparam int RW     = result_width(WIDTH);
  localparam int WORD_W = RW * NUM_REPLICATIONS;
  localparam int LANE_W = $clog2(NUM_REPLICATIONS);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  state_t              state_reg, state_next;
  logic [LANE_W-1:0]   lane_reg, lane_next;
  logic                overflow_reg;
  logic                push, pop;
  logic                full, empty;
  logic [CNT_W-1:0]    count;
  logic [WORD_W-1:0]   wr_word, rd_word;
  logic                last_lane;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REPLICATIONS; gi++) begin : g_pack
      assign wr_word[gi*RW +: RW] = in[gi];
    end
  endgenerate

  vector_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (rd_word),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign last_lane = (lane_reg == LANE_W'(NUM_REPLICATIONS - 1));
  // A full FIFO still takes a vector when the head is leaving on this same edge.
  assign push      = valid_in && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      if (valid_in && !push) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    pop        = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    unique case (state_reg)
      IDLE: begin
        if (!empty) state_next = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_last  = last_lane;
        out_data  = rd_word[lane_reg*RW +: RW];
        if (out_ready) begin
          if (last_lane) begin
            lane_next = '0;
            pop       = 1'b1;
            // Empty after the pop only if nothing is arriving alongside it.
            if (count == CNT_W'(1) && !push) state_next = IDLE;
          end else begin
            lane_next = lane_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = !full;
  assign overflow = overflow_reg;

`ifdef SERIALIZER_LANE_ID_EN
  assign out_lane = lane_reg;
`endif

endmodule
